// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer and its buffer.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer between fetch and decode; head is visible combinationally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [ENTRY_W-1:0]        push_data,
  input  logic                      pop,
  input  logic                      flush,
  output logic [$clog2(DEPTH):0]    count,
  output logic [ENTRY_W-1:0]        head
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_reg [DEPTH];
  logic [AW-1:0]      wr_ptr_reg;
  logic [AW-1:0]      rd_ptr_reg;
  logic [AW:0]        count_reg;

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // Push and pop together while full is legal: count is unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign count = count_reg;
  assign head  = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: single-outstanding imem request FSM, redirect handling, decode FIFO.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

  fetch_state_e       state_reg, state_next;
  logic [31:0]        fetch_pc_reg, fetch_pc_next;
  logic [31:0]        req_pc_reg, req_pc_next;
  logic               discard_reg, discard_next;
  logic               push, pop;
  logic [CW-1:0]      count;
  logic [CW:0]        count_after;
  logic [ENTRY_W-1:0] head_bits;
  fetch_entry_t       head_entry;
  fetch_entry_t       push_entry;

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    req_pc_next   = req_pc_reg;
    discard_next  = discard_reg;
    push          = 1'b0;
    count_after   = {1'b0, count};
    case (state_reg)
      IDLE: if ({1'b0, count} < DEPTH_L) state_next = REQ;
      REQ: begin
        if (imem_gnt) begin
          state_next    = WAIT;
          req_pc_next   = fetch_pc_reg;
          fetch_pc_next = fetch_pc_reg + 32'd4;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          push         = !discard_reg;
          discard_next = 1'b0;
          count_after  = {1'b0, count} + {{CW{1'b0}}, push};
          state_next   = (count_after < DEPTH_L) ? REQ : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Redirect overrides everything above; an accepted-but-unreturned request is marked stale.
    if (redirect) begin
      push          = 1'b0;
      fetch_pc_next = {redirect_pc[31:2], 2'b00};
      case (state_reg)
        IDLE: state_next = REQ;
        REQ:  if (imem_gnt) discard_next = 1'b1;
        WAIT: begin
          if (imem_rvalid) state_next = REQ;
          else             discard_next = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      req_pc_reg   <= RESET_PC;
      discard_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      req_pc_reg   <= req_pc_next;
      discard_reg  <= discard_next;
    end
  end

  assign push_entry.pc    = req_pc_reg;
  assign push_entry.instr = imem_rdata;
  assign pop              = id_valid && id_ready && !redirect;

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .flush    (redirect),
    .count    (count),
    .head     (head_bits)
  );

  assign head_entry = head_bits;
  assign imem_req   = (state_reg == REQ);
  assign imem_addr  = fetch_pc_reg;
  assign id_valid   = (count != '0);
  assign id_instr   = id_valid ? head_entry.instr : 32'd0;
  assign id_pc      = id_valid ? head_entry.pc : 32'd0;
  assign id_pc4     = id_pc + 32'd4;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (id_ready && !id_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (redirect)              perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Sequences instruction fetch for the pipelined CPU. It drives a request/grant/response instruction-memory port, allows at most one outstanding request, and buffers returned words in a small FIFO toward decode. It accepts redirects (branch/jump/jr targets) from decode or execute, which flush the FIFO and discard any in-flight response. It replaces the free-running PC register of the single-cycle fetch unit.

Parameters:
RESET_PC, 32'h0000_3000, first fetch address after reset
FIFO_DEPTH, 2, instruction buffer entries (power of two, ≥2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address, word-aligned
imem_gnt  in  1  memory accepts request this cycle
imem_rvalid  in  1  response data valid
imem_rdata  in  32  returned instruction word
redirect  in  1  flush and restart at redirect_pc
redirect_pc  in  32  new fetch PC, bits [1:0] ignored and forced 0
id_ready  in  1  decode accepts head entry
id_valid  out  1  head entry valid
id_instr  out  32  head instruction
id_pc  out  32  PC of head instruction
id_pc4  out  32  id_pc + 4

Behaviour:
- While reset is low: fetch_pc=RESET_PC, state=IDLE, FIFO empty, discard flag=0, imem_req=0, imem_addr=RESET_PC, id_valid=0, id_instr=0, id_pc=0. Assertion is asynchronous. Deassertion takes effect at the next clk edge.
- FSM states:
  - IDLE: issue condition is count + 0 < FIFO_DEPTH. When it holds, go to REQ.
  - REQ: imem_req=1 and imem_addr=fetch_pc, both held stable until imem_gnt. On gnt, go to WAIT, record req_pc=fetch_pc, set fetch_pc+=4.
  - WAIT: on imem_rvalid, push {req_pc, imem_rdata} unless the discard flag is set, then clear the discard flag. Next state is REQ if count_after_push < FIFO_DEPTH, else IDLE.
- Minimum latency: the request issued in the cycle after reset release. With a zero-wait memory (gnt in the REQ cycle, rvalid the next cycle), id_valid rises 1 cycle after rvalid. Sustained throughput is 1 instruction per 2 cycles.
- FIFO: the head is presented combinationally as id_*. A pop occurs when id_valid && id_ready. Push and pop in the same cycle is legal when full, net count unchanged. The FIFO is never pushed when full, because an issue is only made when space exists.
- Redirect (highest priority), effective the same edge:
  - FIFO is cleared, and a pop in that cycle is irrelevant.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - In REQ without gnt: imem_req stays high, but imem_addr switches to the new PC next cycle. This is legal because the memory has not accepted the request.
  - In REQ with gnt in the same cycle: go to WAIT with discard=1.
  - In WAIT without rvalid: set discard=1.
  - In WAIT with rvalid in the same cycle: the response is dropped, then go to REQ.
  - In IDLE: go to REQ.
- Back-to-back redirects: the last one wins. The discard flag is a single bit, which is sufficient given one outstanding request.
- id_pc4 = id_pc + 4, modulo 2^32. fetch_pc wraps from 32'hFFFF_FFFC to 0 without fault.
- imem_rvalid outside WAIT is ignored.

Optional Feature:
Macro FETCH_PERF_EN.
- Defined: adds output ports perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cnt counts cycles with id_ready=1 && id_valid=0.
  - perf_flush_cnt counts cycles with redirect=1.
  - Both reset to 0, wrap at 2^32, and keep counting during redirect.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package fetch_pkg holds:
  - RESET_PC default constant
  - state encoding: IDLE=2'd0, REQ=2'd1, WAIT=2'd2
  - entry typedef {pc[31:0], instr[31:0]}
- Sub-module fetch_fifo: parameterised depth, push/pop/flush, count, head data. The FSM and redirect logic stay in fetch_sequencer.

Test Plan:
1. Reset release, memory grants immediately and returns 32'h3C010001 next cycle, id_ready=1 → imem_addr sequence 3000, 3004, 3008…; first id_pc=32'h3000, id_instr=32'h3C010001, id_pc4=32'h3004.
2. id_ready=0 with zero-wait memory → FIFO fills to 2 entries (3000, 3004), imem_req stays 0. Raise id_ready → entries pop in order, and fetch resumes at 3008.
3. Redirect to 32'h3042 while in WAIT, with the old response arriving 2 cycles later → old word not pushed; next imem_addr=32'h3040; first id_pc after the flush = 32'h3040.
4. Redirect in the same cycle as imem_gnt for 3004 → response for 3004 dropped; the following request is 3010 when redirect_pc=32'h3010.
5. Redirect in the same cycle as rvalid while the FIFO holds 1 entry → FIFO empty next cycle, id_valid=0, no push.
6. Assert reset low mid-WAIT, asynchronously between edges → outputs go to reset values immediately. After release, fetch restarts at 32'h3000 and late rvalid is ignored. With FETCH_PERF_EN defined, perf counters read 0.
